// File: rtl/fnn_pkg.sv
// fnn_pkg: shared FNN types, default sizes and a lane-extract helper
package fnn_pkg;
    localparam int NEURONS_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int MAX_LANES   = 16;
    localparam int MAX_DW      = 32;
    localparam int MAX_VEC     = MAX_LANES * MAX_DW;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // Returns lane idx of a packed vector of w-bit lanes, low-aligned; caller truncates to w bits.
    function automatic logic [MAX_DW-1:0] lane_get(
        input logic [MAX_VEC-1:0] vec,
        input int unsigned        idx,
        input int unsigned        w
    );
        logic [MAX_VEC-1:0] sh;
        sh = vec >> (idx * w);
        return sh[MAX_DW-1:0];
    endfunction
endpackage

// File: rtl/fnn_max_update.sv
// fnn_max_update: one-lane compare/update of running max (and second-best when FNN_ARGMAX_MARGIN_EN)
module fnn_max_update
    import fnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = 2
)(
    input  logic [DATA_W-1:0] i_best,
    input  logic [IDX_W-1:0]  i_best_idx,
`ifdef FNN_ARGMAX_MARGIN_EN
    input  logic [DATA_W-1:0] i_second,
    output logic [DATA_W-1:0] o_second,
`endif
    input  logic [DATA_W-1:0] i_lane,
    input  logic [IDX_W-1:0]  i_lane_idx,
    output logic [DATA_W-1:0] o_best,
    output logic [IDX_W-1:0]  o_best_idx
);
    logic w_win;

    assign w_win      = i_lane > i_best;
    assign o_best     = w_win ? i_lane : i_best;
    assign o_best_idx = w_win ? i_lane_idx : i_best_idx;
`ifdef FNN_ARGMAX_MARGIN_EN
    assign o_second   = w_win ? i_best : ((i_lane > i_second) ? i_lane : i_second);
`endif
endmodule

// File: rtl/fnn_argmax_stage.sv
// fnn_argmax_stage: sequential argmax over the FNN output lanes; FNN_ARGMAX_MARGIN_EN adds out_margin
module fnn_argmax_stage
    import fnn_pkg::*;
#(
    parameter int NEURONS = NEURONS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 16
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NEURONS*DATA_W-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_class,
    output logic [DATA_W-1:0]         out_score,
`ifdef FNN_ARGMAX_MARGIN_EN
    output logic [DATA_W-1:0]         out_margin,
`endif
    output logic [CNT_W-1:0]          frame_cnt,
    output logic                      busy
);
    state_t                    r_state, w_state_nxt;
    logic [NEURONS*DATA_W-1:0] r_frame;
    logic [DATA_W-1:0]         r_best, w_best_nxt, w_lane;
    logic [IDX_W-1:0]          r_best_idx, w_best_idx_nxt, r_ptr;
    logic [CNT_W-1:0]          r_frame_cnt;
    logic                      w_accept, w_handoff, w_last;
`ifdef FNN_ARGMAX_MARGIN_EN
    logic [DATA_W-1:0]         r_second, w_second_nxt;
`endif

    assign w_accept  = in_valid && in_ready;
    assign w_handoff = out_valid && out_ready;
    assign w_last    = r_ptr == IDX_W'(NEURONS - 1);
    assign w_lane    = DATA_W'(lane_get(MAX_VEC'(r_frame), 32'(r_ptr), DATA_W));

    assign in_ready  = reset_n && (r_state == IDLE);
    assign out_valid = r_state == DONE;
    assign busy      = (r_state == SCAN) || (r_state == DONE);
    assign out_class = r_best_idx;
    assign out_score = r_best;
    assign frame_cnt = r_frame_cnt;
`ifdef FNN_ARGMAX_MARGIN_EN
    assign out_margin = r_best - r_second;
`endif

    fnn_max_update #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_upd (
        .i_best     (r_best),
        .i_best_idx (r_best_idx),
`ifdef FNN_ARGMAX_MARGIN_EN
        .i_second   (r_second),
        .o_second   (w_second_nxt),
`endif
        .i_lane     (w_lane),
        .i_lane_idx (r_ptr),
        .o_best     (w_best_nxt),
        .o_best_idx (w_best_idx_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: accept -> scan remaining lanes -> hold result until handed off
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (NEURONS == 1) ? DONE : SCAN;
            SCAN:    if (w_last) w_state_nxt = DONE;
            DONE:    if (w_handoff) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frame capture, per-lane running max and handoff counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame     <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_ptr       <= '0;
            r_frame_cnt <= '0;
`ifdef FNN_ARGMAX_MARGIN_EN
            r_second    <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_frame    <= in_data;
                r_best     <= in_data[DATA_W-1:0];
                r_best_idx <= '0;
                r_ptr      <= IDX_W'(1);
`ifdef FNN_ARGMAX_MARGIN_EN
                r_second   <= '0;
`endif
            end else if (r_state == SCAN) begin
                r_best     <= w_best_nxt;
                r_best_idx <= w_best_idx_nxt;
                r_ptr      <= r_ptr + 1'b1;
`ifdef FNN_ARGMAX_MARGIN_EN
                r_second   <= w_second_nxt;
`endif
            end
            if (w_handoff) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end
endmodule
